// File: rtl/vote_tally.sv
// Windowed accumulator fed by the 4-input ones-count stage.
// Takes one-hot count codes (0..4), flags illegal codes, and sums decoded values
// over WINDOW accepted samples. Each closed window yields sum, peak, majority and
// error. The result is held until the consumer takes it, so only one window is
// ever in flight.
//
// state | meaning
// ------+--------------------------------------------------------------
// ACCUM | taking samples, in_ready=1, accumulators active
// HOLD  | window result pending on out_*, in_ready=0, waiting out_ready
module vote_tally #(
  parameter int WINDOW = 8,
  parameter int SUM_W  = 6,
  parameter int CNT_W  = 3,
  parameter int THRESH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [2:0]       out_max,
  output logic             out_maj,
  output logic             out_err
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Index of the window-closing sample in the sample counter.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  // Threshold widened so the compare uses the full sum without truncating THRESH.
  localparam logic [31:0] THRESH_U = 32'(THRESH);

  state_t state_q, state_d;

  logic [2:0]       value;
  logic             code_ok;
  logic             accept;
  logic             close;

  logic [SUM_W-1:0] sum_q, sum_nxt;
  logic [2:0]       max_q, max_nxt;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      sum_ext;
  logic             maj_nxt;

  // Decode the one-hot count code; anything not exactly one bit is illegal and counts as 0.
  always_comb begin
    value   = 3'd0;
    code_ok = 1'b1;
    unique case (in_code)
      5'b00001: value = 3'd0;
      5'b00010: value = 3'd1;
      5'b00100: value = 3'd2;
      5'b01000: value = 3'd3;
      5'b10000: value = 3'd4;
      default: begin
        value   = 3'd0;
        code_ok = 1'b0;
      end
    endcase
  end

  assign accept = in_valid & in_ready;
  assign close  = accept & (cnt_q == LAST_IDX);

  // Accumulator values including the sample being accepted this cycle.
  always_comb begin
    sum_nxt = sum_q + SUM_W'(value);
    max_nxt = (value > max_q) ? value : max_q;
    err_nxt = err_q | ~code_ok;
    sum_ext = {{(32 - SUM_W){1'b0}}, sum_nxt};
    maj_nxt = (sum_ext >= THRESH_U);
  end

  // State register; reset dominates any same-cycle accept or handshake.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next-state: close a window into HOLD, release HOLD on the output handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (close)     state_d = HOLD;
      HOLD:  if (out_ready) state_d = ACCUM;
      default:              state_d = ACCUM;
    endcase
  end

  // Handshake outputs decode straight from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ACCUM: in_ready  = 1'b1;
      HOLD:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Window accumulators; cleared on the closing sample so the next window starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      max_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      if (close) begin
        sum_q <= '0;
        max_q <= '0;
        err_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        sum_q <= sum_nxt;
        max_q <= max_nxt;
        err_q <= err_nxt;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Result registers load on the closing sample and otherwise keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum <= '0;
      out_max <= '0;
      out_maj <= 1'b0;
      out_err <= 1'b0;
    end else if (close) begin
      out_sum <= sum_nxt;
      out_max <= max_nxt;
      out_maj <= maj_nxt;
      out_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: a reference model predicts each window result
// into a queue as samples are accepted; results are popped and checked when the
// DUT presents them.
module tb_vote_tally;

  localparam int WINDOW = 8;
  localparam int SUM_W  = 6;
  localparam int THRESH = 16;

  typedef struct {
    int sum;
    int mx;
    int maj;
    int err;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_code;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [2:0]       out_max;
  logic             out_maj;
  logic             out_err;

  int n_checks = 0;
  int n_errors = 0;

  result_t exp_q[$];
  int m_sum = 0, m_max = 0, m_err = 0, m_cnt = 0;

  always #5 clk = ~clk;

  vote_tally #(.WINDOW(WINDOW), .SUM_W(SUM_W), .CNT_W(3), .THRESH(THRESH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_max  (out_max),
    .out_maj  (out_maj),
    .out_err  (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = 0; m_max = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_accept(input logic [4:0] code);
    int v;
    result_t r;
    v = 0;
    case (code)
      5'b00001: v = 0;
      5'b00010: v = 1;
      5'b00100: v = 2;
      5'b01000: v = 3;
      5'b10000: v = 4;
      default:  m_err = 1;
    endcase
    m_sum += v;
    if (v > m_max) m_max = v;
    m_cnt++;
    if (m_cnt == WINDOW) begin
      r.sum = m_sum;
      r.mx  = m_max;
      r.maj = (m_sum >= THRESH) ? 1 : 0;
      r.err = m_err;
      exp_q.push_back(r);
      model_clear();
    end
  endtask

  // Entered and left at a falling edge; waits (bounded) for in_ready.
  task automatic send(input logic [4:0] code);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_code  = code;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", (guard < 50) ? 32'd1 : 32'd0, 32'd1);
    model_accept(code);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Result must be visible right after the closing sample.
  task automatic check_result(input string tag);
    result_t r;
    chk({tag, "_queue"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"},   32'(out_sum),   32'(r.sum));
      chk({tag, "_max"},   32'(out_max),   32'(r.mx));
      chk({tag, "_maj"},   32'(out_maj),   32'(r.maj));
      chk({tag, "_err"},   32'(out_err),   32'(r.err));
    end
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ack_ready"}, 32'(in_ready),  32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held_sum;

    // 1: reset with in_valid high; nothing may be counted
    rst = 1'b1; in_valid = 1'b1; in_code = 5'b00100; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    model_clear();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_max",   32'(out_max),   32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    @(negedge clk);
    chk("rst_in_ready2", 32'(in_ready),  32'd1);

    // 2: 8x value 2, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < WINDOW; i++) begin
      if (i > 0) chk("t2_no_early", 32'(out_valid), 32'd0);
      send(5'b00100);
    end
    check_result("t2");
    @(negedge clk);
    chk("t2_released", 32'(out_valid), 32'd0);
    chk("t2_ready",    32'(in_ready),  32'd1);
    chk("t2_keep_sum", 32'(out_sum),   32'd16);
    out_ready = 1'b0;

    // 3: 8x value 1, consumer stalls 6 cycles while inputs keep offering data
    for (int i = 0; i < WINDOW; i++) send(5'b00010);
    check_result("t3");
    held_sum = 32'(out_sum);
    in_valid = 1'b1; in_code = 5'b10000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_ready", 32'(in_ready),  32'd0);
      chk("t3_hold_sum",   32'(out_sum),   held_sum);
      chk("t3_hold_maj",   32'(out_maj),   32'd0);
    end
    in_valid = 1'b0;
    ack("t3");

    // 4: illegal codes set sticky error; next legal window clears it
    send(5'b00000);
    send(5'b00011);
    for (int i = 0; i < 6; i++) send(5'b10000);
    check_result("t4a");
    ack("t4a");
    for (int i = 0; i < WINDOW; i++) send(5'b00001);
    check_result("t4b");
    ack("t4b");

    // threshold boundary: sum 15 must not flag majority
    for (int i = 0; i < WINDOW - 1; i++) send(5'b00100);
    send(5'b00010);
    check_result("t4c");
    ack("t4c");

    // 5: partial window discarded by reset
    for (int i = 0; i < 5; i++) send(5'b01000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_ready", 32'(in_ready),  32'd1);
    chk("t5_rst_sum",   32'(out_sum),   32'd0);
    for (int i = 0; i < WINDOW; i++) send(5'b00010);
    check_result("t5");
    ack("t5");

    // 6: bubbles between samples are not counted
    for (int i = 0; i < WINDOW; i++) begin
      send(5'b00100);
      if (i < WINDOW - 1) begin
        chk("t6_no_early", 32'(out_valid), 32'd0);
        repeat (i % 3 + 1) @(negedge clk);
      end
    end
    check_result("t6");
    ack("t6");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
